serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Multi-cycle adder that processes DIGIT bits per clock. On an accepted start
//   the operands and carry-in are captured. Each RUN cycle adds the low DIGIT
//   bits of both operand shift registers plus the carry flop. The partial sum
//   enters the result register from the MSB side. After WIDTH/DIGIT steps the
//   block pulses done for one cycle. sum/cout then hold until the next start.
//
// Configuration:
//   SERIAL_ADDER_SUB_EN - adds a 'sub' input and an 'ovf' output. With sub=1
//                         the block computes a - b. B is inverted at capture
//                         and the carry-in is forced to 1. ovf reports
//                         two's-complement signed overflow.
//
// Parameters:
//   WIDTH - operand/result width in bits (2..64)
//   DIGIT - bits added per clock; must divide WIDTH exactly
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   launch request, accepted in IDLE or DONE
//   a, b   in   operands, captured on accepted start
//   cin    in   carry-in, captured on accepted start
//   sub    in   subtract select (SERIAL_ADDER_SUB_EN only)
//   busy   out  high while an operation is running
//   done   out  one-cycle pulse when sum/cout become valid
//   sum    out  result, stable from done until the next accepted start
//   ovf    out  signed overflow (SERIAL_ADDER_SUB_EN only)
//   cout   out  carry-out of the MSB
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = ($clog2(STEPS + 1) < 1) ? 1 : $clog2(STEPS + 1);
  localparam int DW    = DIGIT + 1;

  if (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_err
    $error("serial_adder: illegal WIDTH/DIGIT combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DIGIT:0]   digit_sum;
`ifdef SERIAL_ADDER_SUB_EN
  logic             ovf_q, ovf_d;
`endif

  // One digit of the addition: low DIGIT bits of each operand plus carry.
  assign digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + DW'(carry_q);

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          a_d     = a;
`ifdef SERIAL_ADDER_SUB_EN
          // Subtraction is a + ~b + 1, so the carry-in is forced high.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
        end
      end

      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // New digit enters at the top; after STEPS shifts the first digit
        // has reached the LSB position.
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
        carry_d = digit_sum[DIGIT];
        cout_d  = digit_sum[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
`ifdef SERIAL_ADDER_SUB_EN
        // Carry into the MSB is recovered from the MSB sum bit and its inputs.
        // On the final step this equals the signed overflow of the operation.
        ovf_d   = (a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ digit_sum[DIGIT-1]) ^ digit_sum[DIGIT];
`endif
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops,
  // including the operand and result registers, are cleared by reset so that
  // an aborted operation leaves no stale data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_SUB_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
  assign ovf  = ovf_q;
`endif

endmodule
